// File: rtl/bnn_image_loader_pkg.sv
// Shared types and sizing for the BNN image loader.
// Holds the output FSM state type, the default image geometry and the
// helper used to size word and bit counters.
package bnn_loader_pkg;

    // Counter width for an index range of n entries (never narrower than 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IMG_BITS_DEFAULT = 784;
    localparam int W_DEFAULT        = 8;
    localparam int WORDS_DEFAULT    = IMG_BITS_DEFAULT / W_DEFAULT;
    localparam int PTR_W_DEFAULT    = idx_width(WORDS_DEFAULT);
    localparam int CTR_W_DEFAULT    = idx_width(IMG_BITS_DEFAULT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        STREAM,
        WAIT_DONE
    } loader_state_t;

endpackage

// File: rtl/bnn_image_loader_if.sv
// Host-side pixel stream: W-bit words with a valid/ready handshake.
interface bnn_image_loader_if
    import bnn_loader_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/bnn_image_loader_bank.sv
// One image worth of pixel storage: word-wide writes, single-pixel reads.
// Contents are not reset; a bank is only read after it has been completely
// filled, so stale pixels are never observed.
module loader_bank
    import bnn_loader_pkg::*;
#(
    parameter int  IMG_BITS = IMG_BITS_DEFAULT,
    parameter int  W        = W_DEFAULT,
    localparam int PTR_W    = idx_width(IMG_BITS / W),
    localparam int CTR_W    = idx_width(IMG_BITS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [CTR_W-1:0] raddr,
    output logic             rbit
);
    logic [IMG_BITS-1:0] pixels;

    // Store a host word so that its bit b lands on pixel waddr*W+b.
    always_ff @(posedge clk) begin
        if (we) begin
            pixels[waddr*W +: W] <= wdata;
        end
    end

    assign rbit = pixels[raddr];
endmodule

// File: rtl/bnn_image_loader.sv
// Ping-pong image loader in front of the BNN accelerator.
// The write side fills banks alternately from the host stream; the output
// FSM announces each full bank with a start pulse, shifts its pixels out one
// per cycle and holds the bank until the accelerator reports done.
module bnn_image_loader
    import bnn_loader_pkg::*;
#(
    parameter int IMG_BITS = IMG_BITS_DEFAULT,
    parameter int W        = W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    bnn_image_loader_if.slave        host,
    output logic                     acc_start,
    output logic                     image_out,
    input  logic                     acc_done,
    output logic                     busy,
    output logic [1:0]               banks_full
);
    localparam int WORDS = IMG_BITS / W;
    localparam int PTR_W = idx_width(WORDS);
    localparam int CTR_W = idx_width(IMG_BITS);
    localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(WORDS - 1);
    localparam logic [CTR_W-1:0] LAST_BIT  = CTR_W'(IMG_BITS - 1);

    loader_state_t    state;
    logic             wr_bank;
    logic             rd_bank;
    logic [PTR_W-1:0] wr_ptr;
    logic [CTR_W-1:0] bit_ctr;
    logic [CTR_W-1:0] rd_idx;
    logic [1:0]       full;
    logic             accept;
    logic             bank_release;
    logic             we0;
    logic             we1;
    logic             rbit0;
    logic             rbit1;
    logic             rd_bit;

    assign host.s_ready = !full[wr_bank];
    assign accept       = host.s_valid && !full[wr_bank];
    assign bank_release = (state == WAIT_DONE) && acc_done;
    assign busy         = (state != IDLE);
    assign banks_full   = full;
    assign we0          = accept && !wr_bank;
    assign we1          = accept && wr_bank;

    // image_out is registered, so the banks are addressed one pixel ahead of
    // the pixel currently on the output.
    assign rd_idx = (state == STREAM && bit_ctr != LAST_BIT) ? bit_ctr + CTR_W'(1) : '0;
    assign rd_bit = rd_bank ? rbit1 : rbit0;

    loader_bank #(.IMG_BITS(IMG_BITS), .W(W)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (wr_ptr),
        .wdata (host.s_data),
        .raddr (rd_idx),
        .rbit  (rbit0)
    );

    loader_bank #(.IMG_BITS(IMG_BITS), .W(W)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (wr_ptr),
        .wdata (host.s_data),
        .raddr (rd_idx),
        .rbit  (rbit1)
    );

    // Fill position and full flags; a full bank is never written, so a set
    // and a release can only ever touch different banks in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank <= 1'b0;
            wr_ptr  <= '0;
            full    <= 2'b00;
        end else begin
            if (accept) begin
                if (wr_ptr == LAST_WORD) begin
                    full[wr_bank] <= 1'b1;
                    wr_ptr        <= '0;
                    wr_bank       <= !wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
            end
            if (bank_release) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Output FSM: start pulse, serial stream, then hold until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            bit_ctr   <= '0;
            acc_start <= 1'b0;
            image_out <= 1'b0;
        end else begin
            acc_start <= 1'b0;
            image_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state     <= START;
                        acc_start <= 1'b1;
                    end
                end
                START: begin
                    bit_ctr   <= '0;
                    image_out <= rd_bit;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (bit_ctr == LAST_BIT) begin
                        state <= WAIT_DONE;
                    end else begin
                        bit_ctr   <= bit_ctr + CTR_W'(1);
                        image_out <= rd_bit;
                    end
                end
                WAIT_DONE: begin
                    if (acc_done) begin
                        rd_bank <= !rd_bank;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_image_loader.sv
// Bench for bnn_image_loader with 16-pixel images and 8-bit host words.
// A cycle-level reference model tracks stored images as a queue and derives
// start times, pixel streams, ready and full flags from the loader's rules.
module tb_bnn_image_loader;
    import bnn_loader_pkg::*;

    localparam int IMG = 16;
    localparam int WW  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       acc_start;
    logic       image_out;
    logic       acc_done = 1'b0;
    logic       busy;
    logic [1:0] banks_full;

    bnn_image_loader_if #(.W(WW)) host_if ();

    bnn_image_loader #(.IMG_BITS(IMG), .W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if),
        .acc_start  (acc_start),
        .image_out  (image_out),
        .acc_done   (acc_done),
        .busy       (busy),
        .banks_full (banks_full)
    );

    // Free-running clock and a cycle counter stepped on each active edge.
    always #5 clk = ~clk;

    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [IMG-1:0] img_q[$];
    int             avail_q[$];
    logic [WW-1:0]  part_word;
    bit             have_part;
    int             completed;
    int             released;
    bit             rd_active;
    int             rd_start;
    logic [IMG-1:0] rd_img;
    int             free_cyc;
    bit             last_accept;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_model();
        img_q.delete();
        avail_q.delete();
        part_word   = '0;
        have_part   = 1'b0;
        completed   = 0;
        released    = 0;
        rd_active   = 1'b0;
        rd_start    = 0;
        rd_img      = '0;
        free_cyc    = 0;
        last_accept = 1'b0;
    endtask

    // Called at a falling edge: checks this cycle's outputs, drives inputs
    // for this cycle, advances the model and moves to the next falling edge.
    task automatic applyStimulus(input bit valid, input logic [WW-1:0] data, input bit done);
        int             c;
        int             s;
        int             held;
        bit             exp_start;
        bit             exp_ready;
        logic           exp_pix;
        logic [1:0]     exp_full;
        c         = cyc;
        exp_start = 1'b0;
        if (!rd_active && img_q.size() > 0) begin
            s = ((avail_q[0] > free_cyc) ? avail_q[0] : free_cyc) + 1;
            if (s <= c) begin
                exp_start = 1'b1;
                rd_active = 1'b1;
                rd_start  = c;
                rd_img    = img_q.pop_front();
                void'(avail_q.pop_front());
            end
        end
        exp_pix = 1'b0;
        if (rd_active && c >= rd_start + 1 && c <= rd_start + IMG) begin
            exp_pix = rd_img[c - rd_start - 1];
        end
        held      = completed - released;
        exp_ready = (held < 2);
        exp_full  = 2'b00;
        for (int n = released; n < completed; n++) begin
            exp_full[n % 2] = 1'b1;
        end

        checkOutput("acc_start", acc_start, exp_start);
        checkOutput("image_out", image_out, exp_pix);
        checkOutput("busy", busy, rd_active);
        checkOutput("s_ready", host_if.s_ready, exp_ready);
        checkOutput("banks_full", banks_full, exp_full);

        host_if.s_valid = valid;
        host_if.s_data  = data;
        acc_done        = done;

        last_accept = valid && exp_ready;
        if (last_accept) begin
            if (!have_part) begin
                part_word = data;
                have_part = 1'b1;
            end else begin
                img_q.push_back({data, part_word});
                avail_q.push_back(c + 1);
                completed++;
                have_part = 1'b0;
            end
        end
        if (done && rd_active && c >= rd_start + IMG + 1) begin
            released++;
            rd_active = 1'b0;
            free_cyc  = c + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0);
        end
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        int guard;
        guard = 0;
        last_accept = 1'b0;
        while (!last_accept && guard < 200) begin
            applyStimulus(1'b1, w, 1'b0);
            guard++;
        end
        checkOutput("send_word_timeout", last_accept, 1'b1);
    endtask

    task automatic send_image(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        send_word(w0);
        send_word(w1);
    endtask

    task automatic wait_start();
        int guard;
        guard = 0;
        while (!rd_active && guard < 100) begin
            idle(1);
            guard++;
        end
        checkOutput("wait_start_timeout", rd_active, 1'b1);
    endtask

    task automatic run_until(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 200) begin
            idle(1);
            guard++;
        end
        checkOutput("run_until_timeout", (cyc == target), 1'b1);
    endtask

    // Asserts reset at a falling edge and checks that outputs drop at once.
    task automatic do_reset();
        rst             = 1'b1;
        host_if.s_valid = 1'b0;
        host_if.s_data  = '0;
        acc_done        = 1'b0;
        #1;
        checkOutput("rst_s_ready", host_if.s_ready, 1'b1);
        checkOutput("rst_acc_start", acc_start, 1'b0);
        checkOutput("rst_image_out", image_out, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_banks_full", banks_full, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        int a_start;
        int d_cyc;
        clear_model();
        host_if.s_valid = 1'b0;
        host_if.s_data  = '0;
        @(negedge clk);

        // Reset then idle
        do_reset();
        idle(20);

        // Single image: A5, 3C
        send_image(8'hA5, 8'h3C);
        checkOutput("single_no_start_yet", acc_start, 1'b0);
        idle(1);
        checkOutput("single_start_latency", acc_start, 1'b1);
        idle(17);
        checkOutput("single_busy_wait", busy, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);
        checkOutput("single_idle_after_done", busy, 1'b0);

        // Ping-pong: load B while A streams
        do_reset();
        send_image(8'h5A, 8'hC3);
        wait_start();
        a_start = rd_start;
        send_image(8'hFF, 8'h00);
        run_until(a_start + IMG + 3);
        d_cyc = cyc;
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(1);
        checkOutput("pp_start_done_plus2", acc_start, 1'b1);
        checkOutput("pp_start_cycle", cyc, d_cyc + 2);
        wait_start();
        run_until(rd_start + IMG + 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);

        // Backpressure: three images, no done
        do_reset();
        send_image(8'h11, 8'h22);
        send_image(8'h33, 8'h44);
        idle(2);
        checkOutput("bp_ready_low", host_if.s_ready, 1'b0);
        checkOutput("bp_both_full", banks_full, 2'b11);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 8'h55, 1'b0);
        end
        checkOutput("bp_still_blocked", host_if.s_ready, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b1);
        checkOutput("bp_ready_back", host_if.s_ready, 1'b1);
        send_image(8'h55, 8'h66);
        for (int k = 0; k < 2; k++) begin
            wait_start();
            run_until(rd_start + IMG + 1);
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        idle(3);
        checkOutput("bp_drained", banks_full, 2'b00);

        // Stray done in IDLE and STREAM is ignored
        do_reset();
        idle(2);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(2);
        checkOutput("stray_idle_busy", busy, 1'b0);
        send_image(8'h9C, 8'h63);
        wait_start();
        run_until(rd_start + 6);
        applyStimulus(1'b0, 8'h00, 1'b1);
        run_until(rd_start + IMG + 6);
        checkOutput("stray_still_waiting", busy, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);

        // Reset mid-stream at pixel 7, then a clean reload
        do_reset();
        send_image(8'hE7, 8'h18);
        wait_start();
        run_until(rd_start + 8);
        do_reset();
        idle(2);
        send_image(8'h0F, 8'hF0);
        wait_start();
        checkOutput("reload_bank0", banks_full, 2'b01);
        run_until(rd_start + IMG + 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(3);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
